// File: rtl/mmio_requester.sv
// mmio_requester: host-side MMIO initiator for loopback and self-test builds.
// Turns command-port transactions into MMIO write/read request strobes,
// matches read completions by transaction ID and returns the data.
// Optional feature macro: MMIO_REQ_TIMEOUT_EN enables the read timeout
// counter and rsp_timeout reporting; without it a read waits indefinitely.
module mmio_requester #(
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [63:0] cmd_data,
    output logic        req_wr_valid,
    output logic        req_rd_valid,
    output logic [15:0] req_addr,
    output logic [8:0]  req_tid,
    output logic [1:0]  req_length,
    output logic [63:0] req_data,
    input  logic        cpl_valid,
    input  logic [8:0]  cpl_tid,
    input  logic [63:0] cpl_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_timeout,
    output logic [7:0]  stale_cnt
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] tid_cnt;
    logic       cmd_acc;
    logic       rd_acc;
    logic       cpl_match;
    logic       tmo_hit;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mmio_requester: TIMEOUT_CYCLES out of range 2..65535");
    end

    // Stale completion counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign cmd_ready  = (state == IDLE);
    assign rsp_valid  = (state == RSP);
    assign req_length = 2'b01;
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign rd_acc     = cmd_acc && !cmd_write;
    // The outstanding read's tid is the last issued req_tid, which holds until the next command.
    assign cpl_match  = cpl_valid && (state == RD_WAIT) && (cpl_tid == req_tid);

`ifdef MMIO_REQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;

    // Count cycles spent waiting for the outstanding read; restarts on each read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (rd_acc)
            tmo_cnt <= '0;
        else if (state == RD_WAIT)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_hit = (state == RD_WAIT) && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; a matching completion and a timeout in the same cycle both land in RSP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_acc) state_nxt = RD_WAIT;
            RD_WAIT: if (cpl_match || tmo_hit) state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request strobes, request fields, tid counter, response capture and stale counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr_valid <= 1'b0;
            req_rd_valid <= 1'b0;
            req_addr     <= '0;
            req_tid      <= '0;
            req_data     <= '0;
            tid_cnt      <= '0;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b0;
            stale_cnt    <= '0;
        end else begin
            req_wr_valid <= 1'b0;
            req_rd_valid <= 1'b0;
            if (cmd_acc) begin
                req_addr <= cmd_addr;
                req_tid  <= tid_cnt;
                if (cmd_write) begin
                    req_wr_valid <= 1'b1;
                    req_data     <= cmd_data;
                end else begin
                    req_rd_valid <= 1'b1;
                    tid_cnt      <= tid_cnt + 9'd1;
                end
            end
            if (cpl_match) begin
                rsp_data    <= cpl_data;
                rsp_timeout <= 1'b0;
            end else if (tmo_hit) begin
                rsp_data    <= '0;
                rsp_timeout <= 1'b1;
            end
            if (cpl_valid && !cpl_match)
                stale_cnt <= sat_inc8(stale_cnt);
        end
    end

endmodule

// File: doc/mmio_requester.md
# mmio_requester

Synthesizable CCI-P MMIO initiator that plays the host side of the MMIO protocol. It turns simple command-port transactions into MMIO write and read requests, in the form an AFU sees on Rx c0. It then collects MMIO read completions, in the form an AFU drives on Tx c2, matches them by transaction ID and returns the data. It sits in front of an AFU in loopback and self-test builds so that the AFU's register map can be exercised without a host.

## Interface
Parameters:
- TIMEOUT_CYCLES, 512: cycles a read may wait for its completion before it is reported as timed out; legal range 2..65535.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = MMIO write, 0 = MMIO read.
- cmd_addr  in  16  MMIO address in 4-byte (dword) units.
- cmd_data  in  64  write data; ignored for reads.
- req_wr_valid  out  1  one-cycle MMIO write request strobe.
- req_rd_valid  out  1  one-cycle MMIO read request strobe.
- req_addr  out  16  request address.
- req_tid  out  9  request transaction ID.
- req_length  out  2  request size code; constant 2'b01 (8 bytes).
- req_data  out  64  write payload.
- cpl_valid  in  1  read completion strobe.
- cpl_tid  in  9  completion transaction ID.
- cpl_data  in  64  completion data.
- rsp_valid  out  1  read result available.
- rsp_ready  in  1  result consumed when rsp_valid && rsp_ready.
- rsp_data  out  64  read data; 0 on timeout.
- rsp_timeout  out  1  result is a timeout.
- stale_cnt  out  8  saturating count of unmatched completions.

## Operation
- States: IDLE, RD_WAIT, RSP. cmd_ready = (state == IDLE), decoded combinationally from state.
- Write accepted in IDLE:
  - Next cycle, req_wr_valid=1 for exactly one cycle; req_addr=cmd_addr and req_data=cmd_data.
  - req_tid is the current tid counter value; the counter is not advanced.
  - State stays IDLE, so back-to-back writes issue at one per cycle.
- Read accepted in IDLE:
  - Next cycle, req_rd_valid=1 for one cycle with req_addr=cmd_addr and req_tid=tid counter; the state becomes RD_WAIT in that same cycle.
  - The tid counter increments on the same edge, mod 512 (511 wraps to 0).
- RD_WAIT:
  - On cpl_valid && cpl_tid == the outstanding tid, latch cpl_data, clear rsp_timeout and go to RSP.
  - A completion arriving in the same cycle as the req_rd_valid strobe is accepted.
- Stale completion: cpl_valid with a non-matching tid, or arriving in IDLE or RSP. The completion is discarded and stale_cnt increments, saturating at 255.
- RSP: rsp_valid=1, with rsp_data and rsp_timeout held stable until rsp_ready. Return to IDLE on the handshake edge.
- req_addr, req_data and req_tid hold their last values between strobes.

## Timing
- Reset values: state=IDLE, so cmd_ready=1. req_wr_valid, req_rd_valid, req_addr, req_tid, req_data, rsp_valid, rsp_data, rsp_timeout, stale_cnt and the tid counter are all 0. req_length=2'b01.
- Request latency: strobe 1 cycle after command acceptance.
- Read response latency: rsp_valid is asserted 1 cycle after the matching completion.
- Timeout:
  - The counter clears on entry to RD_WAIT and increments every RD_WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 with no match, go to RSP with rsp_timeout=1 and rsp_data=0.
  - If a matching completion arrives in that same cycle, the completion wins.
  - A completion arriving after a timeout counts as stale.
- Reset asserted mid-operation: all outputs return to reset values immediately. Any outstanding read is abandoned, and its later completion counts as stale.

## Configuration
- MMIO_REQ_TIMEOUT_EN defined: the timeout counter and rsp_timeout behaviour are present as described under Timing.
- Not defined: there is no timeout counter, RD_WAIT waits indefinitely, and rsp_timeout is tied to 0.

## Test plan
- Write cmd_addr=0x0020, cmd_data=0xDEADBEEF_CAFEF00D -> req_wr_valid pulses one cycle later with those values; cmd_ready stays 1.
- Read 0x0020; completion with the matching tid 0 returns 0x1234 three cycles later -> rsp_valid with rsp_data=0x1234, rsp_timeout=0. The next read uses tid 1.
- Completion with tid 5 while tid 0 is outstanding -> ignored, stale_cnt=1. A later tid-0 completion is then accepted.
- With TIMEOUT_CYCLES=16 and no completion -> rsp_valid 16 cycles after RD_WAIT entry, rsp_timeout=1, rsp_data=0 (only with the macro defined).
- Issue 513 reads -> the tid wraps from 511 to 0; hold rsp_ready=0 for 4 cycles -> rsp_data is stable and cmd_ready stays 0.
- Assert rst_n=0 during RD_WAIT -> all outputs reset. After release, a late completion increments stale_cnt.
